// File: rtl/marma_xbar_router_if.sv
// Marma crossbar router bus interface.
// Bundles the per-port flit handshakes, payloads and drop status of the router.
//   in_valid/in_ready/in_dest/in_data  : packed per-input flit push handshake
//   out_valid/out_ready/out_data/out_src : packed per-output registered flit handshake
//   drop_pulse/drop_count               : illegal-destination discard status
// master: the traffic side (drives inputs and out_ready); slave: the router.
interface marma_xbar_router_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 4
);
    localparam int PORT_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]            in_valid;
    logic [NUM_PORTS-1:0]            in_ready;
    logic [NUM_PORTS*DEST_WIDTH-1:0] in_dest;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            out_valid;
    logic [NUM_PORTS-1:0]            out_ready;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
    logic [NUM_PORTS*PORT_W-1:0]     out_src;
    logic                            drop_pulse;
    logic [15:0]                     drop_count;

    modport master (
        output in_valid, in_dest, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src, drop_pulse, drop_count
    );

    modport slave (
        input  in_valid, in_dest, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src, drop_pulse, drop_count
    );
endinterface

// File: rtl/marma_xbar_router.sv
// Marma buffered crossbar router.
// Each input owns a FIFO of {dest, data} entries. Each output has a round-robin
// arbiter over the inputs whose head targets it and a registered valid/ready
// stage that holds its flit under backpressure. Heads with dest >= NUM_PORTS
// are discarded and counted.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave modport of marma_xbar_router_if (flit ports and drop status)
module marma_xbar_router #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int DEST_WIDTH = 4
) (
    input logic                clk,
    input logic                rst,
    marma_xbar_router_if.slave bus
);
    localparam int PORT_W  = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int ENTRY_W = DEST_WIDTH + DATA_WIDTH;
    localparam int unsigned NP = NUM_PORTS;

    logic [ENTRY_W-1:0]              mem [NUM_PORTS][FIFO_DEPTH];
    logic [AW-1:0]                   rd_ptr [NUM_PORTS];
    logic [AW-1:0]                   wr_ptr [NUM_PORTS];
    logic [CW-1:0]                   count [NUM_PORTS];
    logic [PORT_W-1:0]               rr_ptr [NUM_PORTS];
    logic [NUM_PORTS-1:0]            out_valid_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data_q;
    logic [NUM_PORTS*PORT_W-1:0]     out_src_q;
    logic                            drop_pulse_q;
    logic [15:0]                     drop_count_q;

    logic [NUM_PORTS-1:0]  in_ready_c;
    logic [NUM_PORTS-1:0]  push;
    logic [NUM_PORTS-1:0]  head_valid;
    logic [NUM_PORTS-1:0]  head_legal;
    logic [NUM_PORTS-1:0]  drop;
    logic [DEST_WIDTH-1:0] head_dest [NUM_PORTS];
    logic [DATA_WIDTH-1:0] head_data [NUM_PORTS];
    logic [NUM_PORTS-1:0]  out_free;
    logic [NUM_PORTS-1:0]  grant_valid;
    logic [PORT_W-1:0]     grant_src [NUM_PORTS];
    logic [NUM_PORTS-1:0]  pop;
    logic [PORT_W:0]       drop_n;
    logic [16:0]           drop_sum;

    // Input side: acceptance depends on registered occupancy only.
    always_comb begin
        for (int unsigned i = 0; i < NP; i++) begin
            in_ready_c[i] = !rst && (count[i] < CW'(FIFO_DEPTH));
            push[i]       = bus.in_valid[i] && in_ready_c[i];
            head_valid[i] = (count[i] != '0);
            {head_dest[i], head_data[i]} = mem[i][rd_ptr[i]];
            // Zero-extend so NUM_PORTS fits even when it equals 2**DEST_WIDTH.
            head_legal[i] = {1'b0, head_dest[i]} < (DEST_WIDTH + 1)'(NUM_PORTS);
            drop[i]       = head_valid[i] && !head_legal[i];
        end
    end

    // Per-output round-robin arbitration; illegal heads pop unconditionally.
    always_comb begin : arb
        logic [PORT_W-1:0] cand;
        cand   = '0;
        pop    = drop;
        drop_n = '0;
        for (int unsigned i = 0; i < NP; i++) begin
            drop_n = drop_n + (PORT_W + 1)'(drop[i]);
        end
        for (int unsigned j = 0; j < NP; j++) begin
            out_free[j]    = !out_valid_q[j] || bus.out_ready[j];
            grant_valid[j] = 1'b0;
            grant_src[j]   = '0;
            for (int unsigned k = 0; k < NP; k++) begin
                cand = PORT_W'((32'(rr_ptr[j]) + k) % NP);
                if (!grant_valid[j] && head_valid[cand] && head_legal[cand] &&
                    head_dest[cand] == DEST_WIDTH'(j)) begin
                    grant_valid[j] = 1'b1;
                    grant_src[j]   = cand;
                end
            end
            if (out_free[j] && grant_valid[j]) begin
                pop[grant_src[j]] = 1'b1;
            end
        end
        drop_sum = 17'(drop_count_q) + 17'(drop_n);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NP; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
                rr_ptr[i] <= '0;
            end
            out_valid_q  <= '0;
            out_data_q   <= '0;
            out_src_q    <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NP; i++) begin
                if (push[i]) begin
                    mem[i][wr_ptr[i]] <= {bus.in_dest[i*DEST_WIDTH +: DEST_WIDTH],
                                          bus.in_data[i*DATA_WIDTH +: DATA_WIDTH]};
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
            end
            for (int unsigned j = 0; j < NP; j++) begin
                if (out_free[j]) begin
                    out_valid_q[j] <= grant_valid[j];
                    if (grant_valid[j]) begin
                        out_data_q[j*DATA_WIDTH +: DATA_WIDTH] <= head_data[grant_src[j]];
                        out_src_q[j*PORT_W +: PORT_W]          <= grant_src[j];
                        rr_ptr[j] <= (grant_src[j] == PORT_W'(NUM_PORTS - 1)) ?
                                     '0 : grant_src[j] + PORT_W'(1);
                    end
                end
            end
            drop_pulse_q <= |drop;
            drop_count_q <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_src    = out_src_q;
    assign bus.drop_pulse = drop_pulse_q;
    assign bus.drop_count = drop_count_q;
endmodule

// File: tb/tb_marma_xbar_router.sv
// Self-checking bench for marma_xbar_router: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// queue-based reference model of the crossbar.
module tb_marma_xbar_router;
    localparam int NP     = 4;
    localparam int DW     = 64;
    localparam int DEPTH  = 4;
    localparam int DEST_W = 4;
    localparam int PW     = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    marma_xbar_router_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(DEST_W)) bus ();

    marma_xbar_router #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DEST_WIDTH(DEST_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned dest;
        logic [63:0] data;
    } flit_t;

    flit_t       mq [NP][$];
    logic [NP-1:0] mv = '0;
    logic [63:0] mdata [NP] = '{default: '0};
    int          msrc [NP]  = '{default: 0};
    int          mrr  [NP]  = '{default: 0};
    bit          mpulse = 1'b0;
    int          mcnt   = 0;

    function automatic logic [NP-1:0] model_ready();
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = !rst && (mq[i].size() < DEPTH);
        return r;
    endfunction

    bit            m_pop [NP];
    logic [NP-1:0] m_rdy;
    int            m_ndrop, m_win, m_s;
    bit            m_found;
    flit_t         m_f;

    always @(posedge clk) begin
        m_rdy = model_ready();
        if (rst) begin
            for (int i = 0; i < NP; i++) begin
                mq[i].delete();
                mdata[i] = '0;
                msrc[i]  = 0;
                mrr[i]   = 0;
            end
            mv = '0;
            mpulse = 1'b0;
            mcnt = 0;
        end else begin
            m_ndrop = 0;
            for (int i = 0; i < NP; i++) begin
                m_pop[i] = 1'b0;
                if (mq[i].size() > 0 && mq[i][0].dest >= NP) begin
                    m_pop[i] = 1'b1;
                    m_ndrop++;
                end
            end
            for (int j = 0; j < NP; j++) begin
                if (!mv[j] || bus.out_ready[j]) begin
                    m_found = 1'b0;
                    m_win = 0;
                    for (int k = 0; k < NP; k++) begin
                        m_s = (mrr[j] + k) % NP;
                        if (!m_found && mq[m_s].size() > 0 && mq[m_s][0].dest == j) begin
                            m_found = 1'b1;
                            m_win = m_s;
                        end
                    end
                    mv[j] = m_found;
                    if (m_found) begin
                        mdata[j] = mq[m_win][0].data;
                        msrc[j]  = m_win;
                        mrr[j]   = (m_win + 1) % NP;
                        m_pop[m_win] = 1'b1;
                    end
                end
            end
            for (int i = 0; i < NP; i++) begin
                if (m_pop[i]) void'(mq[i].pop_front());
                if (bus.in_valid[i] && m_rdy[i]) begin
                    m_f.dest = bus.in_dest[i*DEST_W +: DEST_W];
                    m_f.data = bus.in_data[i*DW +: DW];
                    mq[i].push_back(m_f);
                end
            end
            mpulse = (m_ndrop > 0);
            mcnt = (mcnt + m_ndrop > 65535) ? 65535 : mcnt + m_ndrop;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 64'(bus.in_ready), 64'(model_ready()));
            check("out_valid", 64'(bus.out_valid), 64'(mv));
            for (int j = 0; j < NP; j++) begin
                if (mv[j]) begin
                    check($sformatf("out_data[%0d]", j), bus.out_data[j*DW +: DW], mdata[j]);
                    check($sformatf("out_src[%0d]", j), 64'(bus.out_src[j*PW +: PW]), 64'(msrc[j]));
                end
            end
            check("drop_pulse", 64'(bus.drop_pulse), 64'(mpulse));
            check("drop_count", 64'(bus.drop_count), 64'(mcnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = '0;
    endtask

    task automatic push(input int i, input int d, input logic [63:0] v);
        bus.in_valid[i] = 1'b1;
        bus.in_dest[i*DEST_W +: DEST_W] = DEST_W'(d);
        bus.in_data[i*DW +: DW] = v;
    endtask

    function automatic logic [63:0] odata(input int j);
        return bus.out_data[j*DW +: DW];
    endfunction

    function automatic logic [63:0] osrc(input int j);
        return 64'(bus.out_src[j*PW +: PW]);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [63:0] got [8];
    int n_got;

    initial begin
        bus.in_valid  = '0;
        bus.in_dest   = '0;
        bus.in_data   = '0;
        bus.out_ready = '1;

        // Reset state
        repeat (2) next_cycle();
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_in_ready", 64'(bus.in_ready), 64'h0);
        check("rst_drop_count", 64'(bus.drop_count), 64'h0);
        check("rst_out_src", 64'(bus.out_src), 64'h0);
        for (int j = 0; j < NP; j++) check("rst_out_data", odata(j), 64'h0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(bus.in_ready), 64'hF);

        // Single flit, 2-cycle latency
        next_cycle();
        push(0, 2, 64'hA5);
        next_cycle(); idle();
        @(negedge clk);
        check("t1_c1_valid", 64'(bus.out_valid), 64'h0);
        next_cycle();
        @(negedge clk);
        check("t1_c2_valid", 64'(bus.out_valid), 64'b0100);
        check("t1_data", odata(2), 64'hA5);
        check("t1_src", osrc(2), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t1_c3_valid", 64'(bus.out_valid), 64'h0);

        // Contention on output 1
        next_cycle();
        push(0, 1, 64'h20); push(1, 1, 64'h21); push(3, 1, 64'h23);
        next_cycle(); idle();
        next_cycle();
        @(negedge clk);
        check("t2_v0", 64'(bus.out_valid[1]), 64'd1);
        check("t2_s0", osrc(1), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t2_s1", osrc(1), 64'd1);
        check("t2_d1", odata(1), 64'h21);
        next_cycle();
        @(negedge clk);
        check("t2_s2", osrc(1), 64'd3);
        next_cycle();
        @(negedge clk);
        check("t2_done", 64'(bus.out_valid[1]), 64'd0);
        next_cycle();
        push(0, 1, 64'h30); push(3, 1, 64'h33);
        next_cycle(); idle();
        next_cycle();
        @(negedge clk);
        check("t2_r2_s0", osrc(1), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t2_r2_s1", osrc(1), 64'd3);
        repeat (2) next_cycle();

        // Backpressure on output 0
        bus.out_ready = 4'b1110;
        for (int v = 1; v <= 6; v++) begin
            idle();
            push(0, 0, 64'(v));
            if (v == 6) begin
                @(negedge clk);
                check("t3_full_ready", 64'(bus.in_ready[0]), 64'd0);
                check("t3_held_data", odata(0), 64'd1);
            end
            next_cycle();
        end
        idle();
        bus.out_ready = '1;
        n_got = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.out_valid[0] && bus.out_ready[0] && n_got < 8) begin
                got[n_got] = odata(0);
                n_got++;
            end
            next_cycle();
        end
        check("t3_count", 64'(n_got), 64'd5);
        for (int k = 0; k < 5; k++) check("t3_order", got[k], 64'(k + 1));
        @(negedge clk);
        check("t3_ready_back", 64'(bus.in_ready[0]), 64'd1);

        // Parallel traffic
        next_cycle();
        for (int i = 0; i < NP; i++) push(i, (i + 1) % NP, 64'(16 + i));
        next_cycle(); idle();
        next_cycle();
        @(negedge clk);
        check("t5_valid", 64'(bus.out_valid), 64'hF);
        check("t5_src", 64'(bus.out_src), 64'h93);
        check("t5_data0", odata(0), 64'h13);
        next_cycle();

        // Illegal destination
        push(2, 7, 64'hDEAD);
        next_cycle(); idle();
        @(negedge clk);
        check("t4_pulse_c1", 64'(bus.drop_pulse), 64'd0);
        next_cycle();
        @(negedge clk);
        check("t4_pulse_c2", 64'(bus.drop_pulse), 64'd1);
        check("t4_count", 64'(bus.drop_count), 64'd1);
        check("t4_no_valid", 64'(bus.out_valid), 64'h0);
        next_cycle();
        @(negedge clk);
        check("t4_pulse_c3", 64'(bus.drop_pulse), 64'd0);
        // Saturation: four drops per cycle until past 0xFFFF
        next_cycle();
        for (int c = 0; c < 16400; c++) begin
            for (int i = 0; i < NP; i++) push(i, 4 + $urandom_range(0, 11), 64'($urandom));
            next_cycle();
        end
        idle();
        repeat (3) next_cycle();
        @(negedge clk);
        check("t4_saturated", 64'(bus.drop_count), 64'hFFFF);

        // Reset mid-operation
        next_cycle();
        bus.out_ready = 4'b1101;
        for (int v = 0; v < 4; v++) begin
            idle();
            push(0, 1, 64'h40 + 64'(v));
            next_cycle();
        end
        idle();
        @(negedge clk);
        check("t6_pre_valid", 64'(bus.out_valid[1]), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 64'(bus.in_ready), 64'h0);
        next_cycle();
        rst = 1'b0;
        bus.out_ready = '1;
        @(negedge clk);
        check("t6_post_valid", 64'(bus.out_valid), 64'h0);
        check("t6_post_ready", 64'(bus.in_ready), 64'hF);
        check("t6_post_count", 64'(bus.drop_count), 64'h0);
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            @(negedge clk);
            check("t6_no_stale", 64'(bus.out_valid), 64'h0);
        end
        next_cycle();
        push(2, 3, 64'h77);
        next_cycle(); idle();
        next_cycle();
        @(negedge clk);
        check("t6_new_valid", 64'(bus.out_valid), 64'b1000);
        check("t6_new_src", osrc(3), 64'd2);
        check("t6_new_data", odata(3), 64'h77);
        next_cycle();

        // Randomized traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            idle();
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < NP; i++) begin
                if ($urandom_range(0, 1) == 1)
                    push(i, ($urandom_range(0, 9) < 9) ? $urandom_range(0, NP - 1)
                                                       : $urandom_range(NP, 15),
                         {$urandom, $urandom});
            end
            for (int j = 0; j < NP; j++) bus.out_ready[j] = ($urandom_range(0, 3) != 0);
            next_cycle();
        end
        idle();
        rst = 1'b0;
        bus.out_ready = '1;
        repeat (20) next_cycle();
        @(negedge clk);
        check("drain_idle", 64'(bus.out_valid), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
